dispatch_unit: RTL and testbench

- Issue-side producer feeding the reservation station's dispatch port: `rdy_from_is`, optype/pc/Qi/Qj/Vi/Vj/imm, and back-pressure via `rs_full`.
- Accepts decoded instructions from the decoder over a valid/ready handshake and holds one instruction in a holding register.
- Resolves operands from register status, with CDB snoop and rename bypass.
- Allocates a ROB tag, renames rd, and presents a one-cycle registered issue pulse to the RS.

---
 rtl/dispatch_unit.sv | 232 +++++++++++++++++++++++
 tb/tb_dispatch_unit.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dispatch_unit.sv
// dispatch_unit
//   Issue-side producer for the reservation station. Accepts one decoded
//   instruction at a time from the decoder (valid/ready), resolves its source
//   operands from register status (with CDB snoop and rename bypass), allocates
//   a ROB tag, renames rd and drives a one-cycle registered issue pulse to the RS.
//
// Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   rdy, flush         global enable (low = pause), synchronous squash
//   dec_*              decoder handshake and instruction fields
//   rf_idx*/rf_Q*/rf_V* register-status query and response
//   rename_*           rename request for rd (combinational, issue cycle)
//   rob_full/rob_tag/rob_alloc  ROB tag allocation
//   cdb_*              common data bus snoop
//   rs_full            RS back-pressure
//   *_2rs              registered issue pulse and payload to the RS
//   stall_cnt          stall cycle counter
//
// Configuration
//   DISPATCH_STALL_CNT_EN  when defined, stall_cnt counts cycles in which a held
//                          instruction could not issue; otherwise it is tied to 0.

module dispatch_unit #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 6,
    parameter int TAG_W  = 5,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rdy,
    input  logic              flush,

    input  logic              dec_valid,
    output logic              dec_ready,
    input  logic [OP_W-1:0]   dec_optype,
    input  logic [DATA_W-1:0] dec_pc,
    input  logic [DATA_W-1:0] dec_imm,
    input  logic [REG_W-1:0]  dec_rs1,
    input  logic [REG_W-1:0]  dec_rs2,
    input  logic [REG_W-1:0]  dec_rd,

    output logic [REG_W-1:0]  rf_idx1,
    output logic [REG_W-1:0]  rf_idx2,
    input  logic [TAG_W-1:0]  rf_Q1,
    input  logic [TAG_W-1:0]  rf_Q2,
    input  logic [DATA_W-1:0] rf_V1,
    input  logic [DATA_W-1:0] rf_V2,

    output logic              rename_en,
    output logic [REG_W-1:0]  rename_rd,
    output logic [TAG_W-1:0]  rename_tag,

    input  logic              rob_full,
    input  logic [TAG_W-1:0]  rob_tag,
    output logic              rob_alloc,

    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_value,

    input  logic              rs_full,
    output logic              rdy_2rs,
    output logic [OP_W-1:0]   optype_2rs,
    output logic [DATA_W-1:0] pc_2rs,
    output logic [TAG_W-1:0]  Qi_2rs,
    output logic [TAG_W-1:0]  Qj_2rs,
    output logic [DATA_W-1:0] Vi_2rs,
    output logic [DATA_W-1:0] Vj_2rs,
    output logic [DATA_W-1:0] imm_2rs,
    output logic [TAG_W-1:0]  dest_2rs,
    output logic [31:0]       stall_cnt
);

    typedef enum logic {EMPTY, FULL} state_t;

    state_t              state;
    logic [OP_W-1:0]     op_h;
    logic [DATA_W-1:0]   pc_h;
    logic [DATA_W-1:0]   imm_h;
    logic [REG_W-1:0]    rd_h;
    logic [TAG_W-1:0]    q1_h, q2_h;
    logic [DATA_W-1:0]   v1_h, v2_h;

    logic                hold_valid;
    logic                issue;
    logic                capture;
    logic [TAG_W-1:0]    q1_new, q2_new, q1_fwd, q2_fwd;
    logic [DATA_W-1:0]   v1_new, v2_new, v1_fwd, v2_fwd;

    assign hold_valid = (state == FULL);
    assign rf_idx1    = dec_rs1;
    assign rf_idx2    = dec_rs2;

    // !rdy_2rs spaces issues two cycles apart so rs_full always reflects
    // the previous issue by the time the next one is decided.
    always_comb begin
        issue     = hold_valid && rdy && !flush && !rs_full && !rob_full && !rdy_2rs;
        dec_ready = rdy && !flush && (!hold_valid || issue);
        capture   = dec_valid && dec_ready;

        rob_alloc  = issue;
        rename_en  = issue && (rd_h != '0);
        rename_rd  = rd_h;
        rename_tag = rob_tag;
    end

    // Operand resolution for an incoming instruction. A source that reads the
    // rd being renamed this very cycle must wait on the new tag, since the
    // register status does not reflect the rename yet; its value is a don't-care
    // and is forced to 0.
    always_comb begin
        q1_new = '0;
        v1_new = '0;
        if (dec_rs1 == '0) begin
            q1_new = '0;
            v1_new = '0;
        end else if (issue && (rd_h != '0) && (dec_rs1 == rd_h)) begin
            q1_new = rob_tag;
            v1_new = '0;
        end else if (cdb_valid && (rf_Q1 != '0) && (cdb_tag == rf_Q1)) begin
            q1_new = '0;
            v1_new = cdb_value;
        end else begin
            q1_new = rf_Q1;
            v1_new = rf_V1;
        end

        q2_new = '0;
        v2_new = '0;
        if (dec_rs2 == '0) begin
            q2_new = '0;
            v2_new = '0;
        end else if (issue && (rd_h != '0) && (dec_rs2 == rd_h)) begin
            q2_new = rob_tag;
            v2_new = '0;
        end else if (cdb_valid && (rf_Q2 != '0) && (cdb_tag == rf_Q2)) begin
            q2_new = '0;
            v2_new = cdb_value;
        end else begin
            q2_new = rf_Q2;
            v2_new = rf_V2;
        end
    end

    // Held operands with this cycle's CDB broadcast applied; used both for the
    // snoop update and for the issue payload.
    always_comb begin
        q1_fwd = q1_h;
        v1_fwd = v1_h;
        if (cdb_valid && (q1_h != '0) && (cdb_tag == q1_h)) begin
            q1_fwd = '0;
            v1_fwd = cdb_value;
        end
        q2_fwd = q2_h;
        v2_fwd = v2_h;
        if (cdb_valid && (q2_h != '0) && (cdb_tag == q2_h)) begin
            q2_fwd = '0;
            v2_fwd = cdb_value;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= EMPTY;
            op_h       <= '0;
            pc_h       <= '0;
            imm_h      <= '0;
            rd_h       <= '0;
            q1_h       <= '0;
            q2_h       <= '0;
            v1_h       <= '0;
            v2_h       <= '0;
            rdy_2rs    <= 1'b0;
            optype_2rs <= '0;
            pc_2rs     <= '0;
            Qi_2rs     <= '0;
            Qj_2rs     <= '0;
            Vi_2rs     <= '0;
            Vj_2rs     <= '0;
            imm_2rs    <= '0;
            dest_2rs   <= '0;
        end else if (flush) begin
            state   <= EMPTY;
            rdy_2rs <= 1'b0;
        end else if (rdy) begin
            rdy_2rs <= issue;
            if (issue) begin
                optype_2rs <= op_h;
                pc_2rs     <= pc_h;
                imm_2rs    <= imm_h;
                Qi_2rs     <= q1_fwd;
                Qj_2rs     <= q2_fwd;
                Vi_2rs     <= v1_fwd;
                Vj_2rs     <= v2_fwd;
                dest_2rs   <= rob_tag;
            end
            if (capture) begin
                state <= FULL;
                op_h  <= dec_optype;
                pc_h  <= dec_pc;
                imm_h <= dec_imm;
                rd_h  <= dec_rd;
                q1_h  <= q1_new;
                q2_h  <= q2_new;
                v1_h  <= v1_new;
                v2_h  <= v2_new;
            end else begin
                if (issue) begin
                    state <= EMPTY;
                end
                q1_h <= q1_fwd;
                q2_h <= q2_fwd;
                v1_h <= v1_fwd;
                v2_h <= v2_fwd;
            end
        end
    end

`ifdef DISPATCH_STALL_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (rdy && !flush && hold_valid && !issue) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_dispatch_unit.sv
// Scoreboard bench for dispatch_unit: directed instructions push their
// hand-computed RS payload into a queue; a monitor pops and compares whenever
// rdy_2rs is presented. Handshake/side outputs are checked inline.

module tb_dispatch_unit;

    logic        clk = 1'b0;
    logic        rst_n, rdy, flush;
    logic        dec_valid, dec_ready;
    logic [5:0]  dec_optype;
    logic [31:0] dec_pc, dec_imm;
    logic [4:0]  dec_rs1, dec_rs2, dec_rd;
    logic [4:0]  rf_idx1, rf_idx2;
    logic [4:0]  rf_Q1, rf_Q2;
    logic [31:0] rf_V1, rf_V2;
    logic        rename_en;
    logic [4:0]  rename_rd, rename_tag;
    logic        rob_full;
    logic [4:0]  rob_tag;
    logic        rob_alloc;
    logic        cdb_valid;
    logic [4:0]  cdb_tag;
    logic [31:0] cdb_value;
    logic        rs_full, rdy_2rs;
    logic [5:0]  optype_2rs;
    logic [31:0] pc_2rs, Vi_2rs, Vj_2rs, imm_2rs;
    logic [4:0]  Qi_2rs, Qj_2rs, dest_2rs;
    logic [31:0] stall_cnt;

    always #5 clk = ~clk;

    dispatch_unit #(.DATA_W(32), .OP_W(6), .TAG_W(5), .REG_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .rdy(rdy), .flush(flush),
        .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_optype(dec_optype),
        .dec_pc(dec_pc), .dec_imm(dec_imm), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
        .dec_rd(dec_rd), .rf_idx1(rf_idx1), .rf_idx2(rf_idx2), .rf_Q1(rf_Q1),
        .rf_Q2(rf_Q2), .rf_V1(rf_V1), .rf_V2(rf_V2), .rename_en(rename_en),
        .rename_rd(rename_rd), .rename_tag(rename_tag), .rob_full(rob_full),
        .rob_tag(rob_tag), .rob_alloc(rob_alloc), .cdb_valid(cdb_valid),
        .cdb_tag(cdb_tag), .cdb_value(cdb_value), .rs_full(rs_full),
        .rdy_2rs(rdy_2rs), .optype_2rs(optype_2rs), .pc_2rs(pc_2rs),
        .Qi_2rs(Qi_2rs), .Qj_2rs(Qj_2rs), .Vi_2rs(Vi_2rs), .Vj_2rs(Vj_2rs),
        .imm_2rs(imm_2rs), .dest_2rs(dest_2rs), .stall_cnt(stall_cnt)
    );

    typedef struct {
        logic [5:0]  op;
        logic [31:0] pc;
        logic [4:0]  qi, qj;
        logic [31:0] vi, vj, imm;
        logic [4:0]  dest;
    } exp_t;

    exp_t sb[$];
    int   total_cnt = 0;
    int   pass_cnt  = 0;
    logic prev_r    = 1'b0;
    logic [31:0] s0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [5:0] op, input logic [31:0] pc, input logic [31:0] imm,
                           input logic [4:0] rs1, input logic [4:0] q1, input logic [31:0] v1,
                           input logic [4:0] rs2, input logic [4:0] q2, input logic [31:0] v2,
                           input logic [4:0] rd);
        dec_valid = 1'b1; dec_optype = op; dec_pc = pc; dec_imm = imm;
        dec_rs1 = rs1; rf_Q1 = q1; rf_V1 = v1;
        dec_rs2 = rs2; rf_Q2 = q2; rf_V2 = v2;
        dec_rd = rd;
    endtask

    task automatic expect_issue(input logic [5:0] op, input logic [31:0] pc,
                                input logic [4:0] qi, input logic [4:0] qj,
                                input logic [31:0] vi, input logic [31:0] vj,
                                input logic [31:0] imm, input logic [4:0] dest);
        exp_t e;
        e.op = op; e.pc = pc; e.qi = qi; e.qj = qj;
        e.vi = vi; e.vj = vj; e.imm = imm; e.dest = dest;
        sb.push_back(e);
    endtask

    // Monitor: every rdy_2rs pulse must match the oldest expected payload and
    // never follow another pulse directly.
    always @(negedge clk) begin
        if (rst_n && rdy_2rs) begin
            chk("issue_spacing", {31'd0, prev_r}, 32'd0);
            if (sb.size() == 0) begin
                total_cnt++;
                $display("FAIL unexpected_issue: rdy_2rs=1 dest=%0d with empty scoreboard at %0t", dest_2rs, $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("optype_2rs", {26'd0, optype_2rs}, {26'd0, e.op});
                chk("pc_2rs",     pc_2rs,  e.pc);
                chk("Qi_2rs",     {27'd0, Qi_2rs}, {27'd0, e.qi});
                chk("Qj_2rs",     {27'd0, Qj_2rs}, {27'd0, e.qj});
                chk("Vi_2rs",     Vi_2rs,  e.vi);
                chk("Vj_2rs",     Vj_2rs,  e.vj);
                chk("imm_2rs",    imm_2rs, e.imm);
                chk("dest_2rs",   {27'd0, dest_2rs}, {27'd0, e.dest});
            end
        end
        prev_r = rdy_2rs;
    end

    initial begin
        rst_n = 1'b0; rdy = 1'b1; flush = 1'b0;
        dec_valid = 1'b0; dec_optype = '0; dec_pc = '0; dec_imm = '0;
        dec_rs1 = '0; dec_rs2 = '0; dec_rd = '0;
        rf_Q1 = '0; rf_Q2 = '0; rf_V1 = '0; rf_V2 = '0;
        rob_full = 1'b0; rob_tag = 5'd1;
        cdb_valid = 1'b0; cdb_tag = '0; cdb_value = '0;
        rs_full = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_rdy_2rs",   {31'd0, rdy_2rs}, 32'd0);
        chk("rst_dec_ready", {31'd0, dec_ready}, 32'd1);
        chk("rst_rename_en", {31'd0, rename_en}, 32'd0);
        chk("rst_rob_alloc", {31'd0, rob_alloc}, 32'd0);
        chk("rst_stall_cnt", stall_cnt, 32'd0);
        chk("rst_dest_2rs",  {27'd0, dest_2rs}, 32'd0);
        chk("rst_pc_2rs",    pc_2rs, 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // Simple ADD with ready operands
        rob_tag = 5'd2;
        present(6'd1, 32'h100, 32'h10, 5'd3, 5'd0, 32'd7, 5'd4, 5'd0, 32'd9, 5'd5);
        chk("rf_idx1", {27'd0, rf_idx1}, 32'd3);
        expect_issue(6'd1, 32'h100, 5'd0, 5'd0, 32'd7, 32'd9, 32'h10, 5'd2);
        tick();
        dec_valid = 1'b0;
        @(negedge clk);
        chk("add_rob_alloc",  {31'd0, rob_alloc}, 32'd1);
        chk("add_rename_en",  {31'd0, rename_en}, 32'd1);
        chk("add_rename_rd",  {27'd0, rename_rd}, 32'd5);
        chk("add_rename_tag", {27'd0, rename_tag}, 32'd2);
        chk("add_dec_ready",  {31'd0, dec_ready}, 32'd1);
        tick(); tick();

        // Pending source woken by CDB while held behind rs_full; stall counting
        rs_full = 1'b1;
        rob_tag = 5'd4;
        present(6'd2, 32'h104, 32'h0, 5'd7, 5'd5, 32'hdead, 5'd0, 5'd0, 32'd0, 5'd8);
        expect_issue(6'd2, 32'h104, 5'd0, 5'd0, 32'h55, 32'd0, 32'h0, 5'd4);
        tick();
        dec_valid = 1'b0;
        cdb_valid = 1'b1; cdb_tag = 5'd5; cdb_value = 32'h55;
        s0 = stall_cnt;
        for (int unsigned i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("stall_no_issue",  {31'd0, rdy_2rs}, 32'd0);
            chk("stall_no_alloc",  {31'd0, rob_alloc}, 32'd0);
            chk("stall_dec_ready", {31'd0, dec_ready}, 32'd0);
            tick();
            cdb_valid = 1'b0;
        end
`ifdef DISPATCH_STALL_CNT_EN
        chk("stall_cnt_plus4", stall_cnt, s0 + 32'd4);
`else
        chk("stall_cnt_off", stall_cnt, 32'd0);
`endif
        rs_full = 1'b0;
        tick(); tick();

        // Back-to-back: I2 reads I1's rd while I1 issues -> rename bypass
        rob_tag = 5'd3;
        present(6'd3, 32'h108, 32'h20, 5'd0, 5'd0, 32'd0, 5'd0, 5'd0, 32'd0, 5'd6);
        expect_issue(6'd3, 32'h108, 5'd0, 5'd0, 32'd0, 32'd0, 32'h20, 5'd3);
        tick();
        present(6'd4, 32'h10c, 32'h0, 5'd6, 5'd0, 32'h11, 5'd0, 5'd0, 32'd0, 5'd9);
        expect_issue(6'd4, 32'h10c, 5'd3, 5'd0, 32'd0, 32'd0, 32'h0, 5'd4);
        @(negedge clk);
        chk("b2b_i1_alloc",     {31'd0, rob_alloc}, 32'd1);
        chk("b2b_dec_ready",    {31'd0, dec_ready}, 32'd1);
        chk("b2b_i1_rename_rd", {27'd0, rename_rd}, 32'd6);
        tick();
        dec_valid = 1'b0;
        rob_tag = 5'd4;
        @(negedge clk);
        chk("b2b_gap_no_alloc", {31'd0, rob_alloc}, 32'd0);
        tick();
        @(negedge clk);
        chk("b2b_i2_alloc",     {31'd0, rob_alloc}, 32'd1);
        tick(); tick();

        // CDB hit at capture (rs1) and at issue (rs2); rd=0 means no rename
        rob_tag = 5'd5;
        cdb_valid = 1'b1; cdb_tag = 5'd7; cdb_value = 32'h77;
        present(6'd5, 32'h110, 32'h30, 5'd1, 5'd7, 32'd0, 5'd2, 5'd6, 32'd0, 5'd0);
        expect_issue(6'd5, 32'h110, 5'd0, 5'd0, 32'h77, 32'h66, 32'h30, 5'd5);
        tick();
        dec_valid = 1'b0;
        cdb_tag = 5'd6; cdb_value = 32'h66;
        @(negedge clk);
        chk("cdb_rob_alloc", {31'd0, rob_alloc}, 32'd1);
        chk("rd0_rename_en", {31'd0, rename_en}, 32'd0);
        tick();
        cdb_valid = 1'b0;
        tick();

        // Flush while an instruction is held and about to issue
        rob_tag = 5'd6;
        present(6'd6, 32'h114, 32'h0, 5'd0, 5'd0, 32'd0, 5'd0, 5'd0, 32'd0, 5'd10);
        tick();
        dec_valid = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        chk("flush_no_alloc",  {31'd0, rob_alloc}, 32'd0);
        chk("flush_no_rename", {31'd0, rename_en}, 32'd0);
        chk("flush_dec_ready", {31'd0, dec_ready}, 32'd0);
        tick();
        flush = 1'b0;
        @(negedge clk);
        chk("post_flush_rdy_2rs",  {31'd0, rdy_2rs}, 32'd0);
        chk("post_flush_empty",    {31'd0, dec_ready}, 32'd1);
        chk("post_flush_no_alloc", {31'd0, rob_alloc}, 32'd0);
        tick(); tick();

        // rdy low freezes everything
        rob_tag = 5'd7;
        present(6'd7, 32'h118, 32'h0, 5'd0, 5'd0, 32'd0, 5'd0, 5'd0, 32'd0, 5'd11);
        expect_issue(6'd7, 32'h118, 5'd0, 5'd0, 32'd0, 32'd0, 32'h0, 5'd7);
        tick();
        dec_valid = 1'b0;
        rdy = 1'b0;
        s0 = stall_cnt;
        for (int unsigned i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("pause_dec_ready", {31'd0, dec_ready}, 32'd0);
            chk("pause_no_alloc",  {31'd0, rob_alloc}, 32'd0);
            chk("pause_no_rename", {31'd0, rename_en}, 32'd0);
            tick();
        end
        chk("pause_stall_frozen", stall_cnt, s0);
        rdy = 1'b1;
        tick(); tick();

        // Reset while FULL
        rob_tag = 5'd8;
        rs_full = 1'b1;
        present(6'd8, 32'h11c, 32'h0, 5'd0, 5'd0, 32'd0, 5'd0, 5'd0, 32'd0, 5'd12);
        tick();
        dec_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_rdy_2rs",   {31'd0, rdy_2rs}, 32'd0);
        chk("midrst_dec_ready", {31'd0, dec_ready}, 32'd1);
        chk("midrst_stall_cnt", stall_cnt, 32'd0);
        chk("midrst_dest_2rs",  {27'd0, dest_2rs}, 32'd0);
        tick();
        rst_n = 1'b1;
        rs_full = 1'b0;
        @(negedge clk);
        chk("postrst_dec_ready", {31'd0, dec_ready}, 32'd1);
        chk("postrst_no_alloc",  {31'd0, rob_alloc}, 32'd0);
        tick(); tick();

        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
